// File: rtl/ring_counter.sv
// One-hot ring counter: a single 1 rotates through Q by one position per clock, so the period is WIDTH cycles.
// When RING_COUNTER_SELF_CORRECT_EN is defined, any non-one-hot state is replaced by INIT on the next edge.
module ring_counter #(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] INIT  = WIDTH'(1),
  parameter bit               DIR   = 1'b0
) (
  input  logic             CLK,
  input  logic             Reset,
  output logic [WIDTH-1:0] Q
);

  if (WIDTH < 2) begin : g_bad_width
    $error("ring_counter: WIDTH must be at least 2");
  end

  if ((INIT == '0) || ((INIT & (INIT - WIDTH'(1))) != '0)) begin : g_bad_init
    $error("ring_counter: INIT must be one-hot");
  end

  logic [WIDTH-1:0] rot;
  logic [WIDTH-1:0] nxt;

  always_comb begin
    rot = '0;
    if (DIR) rot = {Q[0], Q[WIDTH-1:1]};
    else     rot = {Q[WIDTH-2:0], Q[WIDTH-1]};
  end

`ifdef RING_COUNTER_SELF_CORRECT_EN
  logic onehot;

  // Clearing the lowest set bit leaves zero only if exactly one bit was set.
  always_comb begin
    onehot = (Q != '0) && ((Q & (Q - WIDTH'(1))) == '0);
    nxt    = onehot ? rot : INIT;
  end
`else
  always_comb begin
    nxt = rot;
  end
`endif

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) Q <= INIT;
    else       Q <= nxt;
  end

endmodule

// File: tb/tb_ring_counter.sv
// Directed bench for ring_counter. It runs a default 4-bit left-rotating instance and a 6-bit right-rotating instance side by side.
module tb_ring_counter;

  logic       CLK;
  logic       Reset;
  logic [3:0] q4;
  logic [5:0] q6;

  int vectors     = 0;
  int miscompares = 0;

  ring_counter dut4 (
    .CLK   (CLK),
    .Reset (Reset),
    .Q     (q4)
  );

  ring_counter #(.WIDTH(6), .INIT(6'b000001), .DIR(1'b1)) dut6 (
    .CLK   (CLK),
    .Reset (Reset),
    .Q     (q6)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected values after edges at 15, 25, ... 105 ns.
  logic [3:0] exp4 [10] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010,
                            4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
  logic [5:0] exp6 [10] = '{6'b100000, 6'b010000, 6'b001000, 6'b000100, 6'b000010,
                            6'b000001, 6'b100000, 6'b010000, 6'b001000, 6'b000100};
`ifdef RING_COUNTER_SELF_CORRECT_EN
  logic [3:0] exp_zero [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                               4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] exp_fix = 4'b0001;
`else
  logic [3:0] exp_zero [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000,
                               4'b0000, 4'b0000, 4'b0000, 4'b0000};
  logic [3:0] exp_fix = 4'b1100;
`endif

  initial begin
    Reset = 1'b1;
    #1;
    chk("async_reset_q4", 32'(q4), 32'(4'b0001));
    chk("async_reset_q6", 32'(q6), 32'(6'b000001));
    #7;
    chk("reset_hold_q4", 32'(q4), 32'(4'b0001));
    chk("reset_hold_q6", 32'(q6), 32'(6'b000001));
    #2;
    Reset = 1'b0;

    for (int k = 0; k < 10; k++) begin
      #10;
      chk($sformatf("rot_q4_e%0d", k + 1), 32'(q4), 32'(exp4[k]));
      chk($sformatf("rot_q6_e%0d", k + 1), 32'(q6), 32'(exp6[k]));
    end

    // t=110: q4 = 0100, so assert reset between edges.
    #1;
    Reset = 1'b1;
    #1;
    chk("mid_reset_q4", 32'(q4), 32'(4'b0001));
    chk("mid_reset_q6", 32'(q6), 32'(6'b000001));
    #1;
    Reset = 1'b0;
    #10;
    chk("restart_q4", 32'(q4), 32'(4'b0010));
    chk("restart_q6", 32'(q6), 32'(6'b100000));

    // t=123; edge at 125 moves q4 to 0100, then 0110 is injected.
    #4;
    force dut4.Q = 4'b0110;
    #1;
    release dut4.Q;
    #1;
    chk("inject_0110", 32'(q4), 32'(4'b0110));
    #11;
    chk("after_0110", 32'(q4), 32'(exp_fix));

    // t=140; a zero state is injected here.
    #1;
    force dut4.Q = 4'b0000;
    #1;
    release dut4.Q;
    #1;
    chk("inject_0000", 32'(q4), 32'(4'b0000));
    for (int k = 0; k < 8; k++) begin
      #10;
      chk($sformatf("zero_e%0d", k + 1), 32'(q4), 32'(exp_zero[k]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
